ysyx_24110006_lsu_axi: RTL
==========================

// Module: ysyx_24110006_lsu_axi
// PURPOSE
//   Parametrised load/store unit with an external AXI4-Lite master port; replaces the fixed 32-bit LSU
//   with its private SRAM. Sits between EXU and WBU: takes one memory request per handshake, aligns and
//   masks it for the bus, and returns extended load data. Also returns an error code for misaligned
//   accesses, bus error responses and channel timeouts.
// PARAMETERS
//   ADDR_W   32   address width
//   DATA_W   32   bus/data width, 32 or 64 only; NB = DATA_W/8 byte lanes
//   TIMEOUT  255  max cycles waiting in ADDR or RESP before timeout error; 0 = never time out
// PORTS
//   i_clock    in   1         clock
//   i_reset    in   1         synchronous, active-high reset
//   i_valid    in   1         request valid (upstream)
//   o_ready    out  1         LSU idle, can accept request
//   i_ren      in   1         load request
//   i_wen      in   1         store request (wins if i_ren also set)
//   i_addr     in   ADDR_W    byte address
//   i_wdata    in   DATA_W    store data, LSB-justified
//   i_op       in   3         [1:0] size 0=B 1=H 2=W 3=D; [2] zero-extend load (else sign-extend)
//   o_valid    out  1         result valid (downstream)
//   i_ready    in   1         downstream accepts result
//   o_rdata    out  DATA_W    extended load data; 0 for stores, no-ops and errors
//   o_err      out  2         00 ok, 01 misaligned, 10 bus error (resp!=0), 11 timeout
//   o_araddr/o_arvalid/i_arready, i_rdata/i_rresp[1:0]/i_rvalid/o_rready,
//   o_awaddr/o_awvalid/i_awready, o_wdata/o_wstrb[NB]/o_wvalid/i_wready,
//   i_bresp[1:0]/i_bvalid/o_bready      AXI4-Lite master; standard directions and widths
// BEHAVIOUR
//   Reset: state IDLE; o_valid, all AXI valid/ready, o_err and o_rdata = 0; o_ready = 1 from the first cycle
//     after reset. Reset mid-transaction abandons the transaction without producing a result.
//   o_ready = (state==IDLE). A request is accepted on i_valid&&o_ready. All request fields are latched
//     at acceptance. i_* are ignored at all other times.
//   FSM IDLE->ADDR->RESP->DONE->IDLE. Accept cycle goes straight to DONE in two cases:
//     - no-op (!ren&&!wen): o_err=00.
//     - misaligned (addr % (1<<size) != 0, or size=3 with DATA_W=32): o_err=01; no bus traffic.
//   ADDR, read: o_arvalid=1 from the cycle after accept. It holds until arready; then RESP.
//   ADDR, write: o_awvalid and o_wvalid rise together. Each drops on its own handshake. Go to RESP once
//     both handshakes have occurred, in the same cycle or in different cycles.
//   Bus address = addr with the low log2(NB) bits cleared; off = those bits.
//   Write lanes: o_wdata = i_wdata << 8*off; o_wstrb = ((1<<(1<<size))-1) << off.
//   RESP: o_rready (read) or o_bready (write) = 1. It holds until the valid is seen, then DONE.
//     resp!=0 -> o_err=10.
//   Load data = (i_rdata >> 8*off), truncated to the size and extended per i_op[2]; captured on r handshake.
//   Timeout: a counter clears on entry to ADDR and to RESP. When it reaches TIMEOUT: drop all AXI
//     valid/ready, DONE with o_err=11.
//   DONE: o_valid=1 with stable o_rdata/o_err until i_ready. On the handshake go to IDLE; o_ready is 1
//     the next cycle.
//   Minimum load latency, zero-wait slave: accept at T0, arvalid at T1, rready at T2, o_valid at T3.
//   One transaction in flight; no AXI IDs or bursts; AXI valids never depend combinationally on readies.
// TESTING
//   lw 0x8000_0004, slave immediate, rdata=0xDEADBEEF -> araddr 0x8000_0004 at T1, o_valid T3, o_rdata 0xDEADBEEF, err 00
//   lb 0x8000_0003 signed, rdata=0x80FF_0000 -> o_rdata 0xFFFF_FF80; same lbu -> 0x0000_0080
//   sh 0x8000_0002 wdata 0x1234, awready 3 cycles after wready -> wdata 0x1234_0000, wstrb 1100, one aw and one w handshake
//   lw 0x8000_0002 -> o_valid 1 cycle after accept, err 01, arvalid/awvalid never asserted
//   rresp=2'b10 -> err 10; slave never asserts bvalid, TIMEOUT=8 -> err 11 after 8 cycles in RESP, bready low
//   i_ready held low 5 cycles in DONE -> o_valid/o_rdata stable, o_ready 0; reset in RESP -> IDLE, no o_valid

Source files
------------

// File: rtl/ysyx_24110006_lsu_axi_if.sv
// AXI4-Lite bus between the LSU (master) and a memory/peripheral slave.
// Channels: ar (read address), r (read data/resp), aw (write address),
// w (write data/strobes), b (write response). Single outstanding access,
// no IDs, no bursts.
`timescale 1ns/1ps
interface ysyx_24110006_lsu_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_24110006_lsu_axi.sv
// Load/store unit with an AXI4-Lite master port. Accepts one request per
// i_valid/o_ready handshake, issues a single aligned bus access, and returns
// extended load data plus an error code on the o_valid/i_ready handshake.
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_valid/o_ready           request handshake (upstream)
//   i_ren/i_wen/i_addr/i_wdata/i_op   request fields, latched at acceptance
//   o_valid/i_ready           result handshake (downstream)
//   o_rdata/o_err             result: load data, error (00 ok, 01 misaligned,
//                             10 bus error, 11 timeout)
//   axi                       AXI4-Lite master
`timescale 1ns/1ps
module ysyx_24110006_lsu_axi #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_ren,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_op,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_err,
    ysyx_24110006_lsu_axi_if.master axi
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StResp = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrAlign   = 2'd1;
    localparam logic [1:0] ErrBus     = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    // Last counter value before a timeout fires: a phase lasts at most TIMEOUT cycles.
    localparam logic [31:0] ToLast = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              is_write_q, is_write_d;
    logic [1:0]        size_q, size_d;
    logic              zext_q, zext_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;
    logic              arvalid_q, arvalid_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;

    logic              misaligned;
    logic [2:0]        align_mask;
    logic [NB-1:0]     strb_base;
    logic              to_hit;
    logic              aw_done, w_done;
    logic [DATA_W-1:0] rd_shift, rd_mask, load_ext;
    logic              rd_sign;

    // Request decode (only meaningful while idle).
    always_comb begin
        // For size 3 the shift wraps to 0 and the mask becomes 3'b111.
        align_mask = (3'd1 << i_op[1:0]) - 3'd1;
        misaligned = (|(i_addr[2:0] & align_mask)) || ((i_op[1:0] == 2'd3) && (DATA_W == 32));
        // Full-width shift wraps to 0, so the subtraction yields all lanes.
        strb_base  = (NB'(1) << (4'd1 << i_op[1:0])) - NB'(1);
    end

    // Load data: move the addressed bytes to the LSB, mask to size, then extend.
    always_comb begin
        rd_shift = axi.rdata >> {off_q, 3'b000};
        rd_mask  = (DATA_W'(1) << (7'd8 << size_q)) - DATA_W'(1);
        case (size_q)
            2'd0:    rd_sign = rd_shift[7];
            2'd1:    rd_sign = rd_shift[15];
            2'd2:    rd_sign = rd_shift[31];
            default: rd_sign = rd_shift[DATA_W-1];
        endcase
        load_ext = (rd_shift & rd_mask) | ((rd_sign && !zext_q) ? ~rd_mask : '0);
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        size_d     = size_q;
        zext_d     = zext_q;
        off_d      = off_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        arvalid_d  = arvalid_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        to_hit     = (TIMEOUT != 0) && (cnt_q == ToLast);
        aw_done    = !awvalid_q || axi.awready;
        w_done     = !wvalid_q || axi.wready;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    is_write_d = i_wen;
                    size_d     = i_op[1:0];
                    zext_d     = i_op[2];
                    off_d      = i_addr[OFF_W-1:0];
                    addr_d     = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_d    = i_wdata << {i_addr[OFF_W-1:0], 3'b000};
                    wstrb_d    = strb_base << i_addr[OFF_W-1:0];
                    rdata_d    = '0;
                    err_d      = ErrOk;
                    cnt_d      = '0;
                    if (!i_ren && !i_wen) begin
                        state_d = StDone;
                    end else if (misaligned) begin
                        err_d   = ErrAlign;
                        state_d = StDone;
                    end else begin
                        state_d = StAddr;
                        if (i_wen) begin
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end else begin
                            arvalid_d = 1'b1;
                        end
                    end
                end
            end
            StAddr: begin
                cnt_d = cnt_q + 32'd1;
                if (is_write_q) begin
                    // aw and w complete independently; either may finish first.
                    if (axi.awready) awvalid_d = 1'b0;
                    if (axi.wready)  wvalid_d  = 1'b0;
                    if (aw_done && w_done) begin
                        state_d = StResp;
                        cnt_d   = '0;
                    end else if (to_hit) begin
                        awvalid_d = 1'b0;
                        wvalid_d  = 1'b0;
                        err_d     = ErrTimeout;
                        state_d   = StDone;
                    end
                end else begin
                    if (axi.arready) begin
                        arvalid_d = 1'b0;
                        state_d   = StResp;
                        cnt_d     = '0;
                    end else if (to_hit) begin
                        arvalid_d = 1'b0;
                        err_d     = ErrTimeout;
                        state_d   = StDone;
                    end
                end
            end
            StResp: begin
                cnt_d = cnt_q + 32'd1;
                if (is_write_q && axi.bvalid) begin
                    err_d   = (axi.bresp != 2'b00) ? ErrBus : ErrOk;
                    state_d = StDone;
                end else if (!is_write_q && axi.rvalid) begin
                    if (axi.rresp != 2'b00) begin
                        err_d   = ErrBus;
                        rdata_d = '0;
                    end else begin
                        rdata_d = load_ext;
                    end
                    state_d = StDone;
                end else if (to_hit) begin
                    err_d   = ErrTimeout;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (i_ready) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            size_q     <= 2'd0;
            zext_q     <= 1'b0;
            off_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= ErrOk;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            size_q     <= size_d;
            zext_q     <= zext_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            arvalid_q  <= arvalid_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign o_ready     = (state_q == StIdle);
    assign o_valid     = (state_q == StDone);
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;

    assign axi.araddr  = addr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = (state_q == StResp) && !is_write_q;
    assign axi.awaddr  = addr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = (state_q == StResp) && is_write_q;
endmodule
